// File: rtl/multicycle_control_pkg.sv
// Shared opcodes, ALUOp encodings, FSM states and instruction classes
// for the multi-cycle RV32I control unit.
package multicycle_control_pkg;

  localparam int unsigned OP_W       = 7;
  localparam int unsigned ALUOP_BASE_W = 2;

  localparam logic [OP_W-1:0] OP_R  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LD = 7'b0000011;
  localparam logic [OP_W-1:0] OP_ST = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BR = 7'b1100011;

  localparam logic [ALUOP_BASE_W-1:0] ALUOP_R    = 2'b00;
  localparam logic [ALUOP_BASE_W-1:0] ALUOP_I    = 2'b10;
  localparam logic [ALUOP_BASE_W-1:0] ALUOP_ADDR = 2'b01;
  localparam logic [ALUOP_BASE_W-1:0] ALUOP_CMP  = 2'b11;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_e;

  typedef enum logic [2:0] {CL_R, CL_I, CL_LD, CL_ST, CL_BR, CL_ILL} iclass_e;

  typedef struct packed {
    iclass_e                 cls;
    logic [ALUOP_BASE_W-1:0] aluop;
    logic                    alusrc;
  } decode_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction/data memory valid-ready handshake between the control unit
// (master) and the memories (slave).
interface multicycle_control_if;
  logic imem_req_o;
  logic imem_ready_i;
  logic dmem_req_o;
  logic dmem_ready_i;

  modport master (output imem_req_o, output dmem_req_o,
                  input  imem_ready_i, input dmem_ready_i);
  modport slave  (input  imem_req_o, input dmem_req_o,
                  output imem_ready_i, output dmem_ready_i);
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational opcode classifier; the result is captured by the top
// only while in DECODE.
module multicycle_control_decode
  import multicycle_control_pkg::*;
#(
  parameter bit EN_BRANCH = 1'b1
) (
  input  logic [OP_W-1:0] op_i,
  output decode_t         dec_c_o
);

  always_comb begin : classify
    dec_c_o = '{cls: CL_ILL, aluop: ALUOP_R, alusrc: 1'b0};
    case (op_i)
      OP_R:  dec_c_o = '{cls: CL_R,  aluop: ALUOP_R,    alusrc: 1'b0};
      OP_I:  dec_c_o = '{cls: CL_I,  aluop: ALUOP_I,    alusrc: 1'b1};
      OP_LD: dec_c_o = '{cls: CL_LD, aluop: ALUOP_ADDR, alusrc: 1'b1};
      OP_ST: dec_c_o = '{cls: CL_ST, aluop: ALUOP_ADDR, alusrc: 1'b1};
      OP_BR: if (EN_BRANCH) dec_c_o = '{cls: CL_BR, aluop: ALUOP_CMP, alusrc: 1'b0};
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory handshakes with bounded wait, and sticky illegal/timeout trap.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 2,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          EN_BRANCH   = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [OP_W-1:0]       Op_i,
  input  logic                  zero_i,
  multicycle_control_if.master  mem_if,
  output logic                  ir_we_o,
  output logic                  pc_we_o,
  output logic                  pc_sel_o,
  output logic [ALUOP_W-1:0]    ALUOp_o,
  output logic                  ALUSrc_o,
  output logic                  MemWrite_o,
  output logic                  MemToReg_o,
  output logic                  RegWrite_o,
  output logic                  trap_o,
  output logic                  trap_cause_o
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e           state_q, state_d;
  decode_t          dec_q, dec_d, dec_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cause_q, cause_d;
  logic             run_q, run_d;
  logic             timeout_c;

  multicycle_control_decode #(.EN_BRANCH(EN_BRANCH)) u_decode (
    .op_i    (Op_i),
    .dec_c_o (dec_c)
  );

  assign timeout_c = (cnt_q == CNT_W'(MEM_TIMEOUT));

  // run_q keeps the fetch request low until the first clock after reset release
  always_ff @(posedge clk_i or negedge rst_n_i) begin : state_reg
    if (!rst_n_i) begin
      state_q <= FETCH;
      dec_q   <= '{cls: CL_ILL, aluop: ALUOP_R, alusrc: 1'b0};
      cnt_q   <= '0;
      cause_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      run_q   <= run_d;
    end
  end

  always_comb begin : next_state_out
    state_d           = state_q;
    dec_d             = dec_q;
    cnt_d             = cnt_q;
    cause_d           = cause_q;
    run_d             = 1'b1;
    mem_if.imem_req_o = 1'b0;
    mem_if.dmem_req_o = 1'b0;
    ir_we_o           = 1'b0;
    pc_we_o           = 1'b0;
    pc_sel_o          = 1'b0;
    ALUOp_o           = '0;
    ALUSrc_o          = 1'b0;
    MemWrite_o        = 1'b0;
    MemToReg_o        = 1'b0;
    RegWrite_o        = 1'b0;
    trap_o            = 1'b0;
    trap_cause_o      = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (run_q) begin
          mem_if.imem_req_o = 1'b1;
          if (mem_if.imem_ready_i) begin
            ir_we_o = 1'b1;
            pc_we_o = 1'b1;
            state_d = DECODE;
          end else if (timeout_c) begin
            state_d = TRAP;
            cause_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DECODE: begin
        dec_d = dec_c;
        if (dec_c.cls == CL_ILL) begin
          state_d = TRAP;
          cause_d = 1'b0;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        ALUOp_o  = ALUOP_W'(dec_q.aluop);
        ALUSrc_o = dec_q.alusrc;
        case (dec_q.cls)
          CL_R, CL_I:   state_d = WB;
          CL_LD, CL_ST: state_d = MEM;
          CL_BR: begin
            pc_we_o  = zero_i;
            pc_sel_o = zero_i;
            state_d  = FETCH;
          end
          default: begin
            state_d = TRAP;
            cause_d = 1'b0;
          end
        endcase
      end
      MEM: begin
        ALUOp_o           = ALUOP_W'(dec_q.aluop);
        ALUSrc_o          = dec_q.alusrc;
        mem_if.dmem_req_o = 1'b1;
        MemWrite_o        = (dec_q.cls == CL_ST);
        if (mem_if.dmem_ready_i) begin
          state_d = (dec_q.cls == CL_LD) ? WB : FETCH;
        end else if (timeout_c) begin
          state_d = TRAP;
          cause_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WB: begin
        ALUOp_o    = ALUOP_W'(dec_q.aluop);
        ALUSrc_o   = dec_q.alusrc;
        RegWrite_o = 1'b1;
        MemToReg_o = (dec_q.cls == CL_LD);
        state_d    = FETCH;
      end
      TRAP: begin
        trap_o       = 1'b1;
        trap_cause_o = cause_q;
      end
      default: state_d = TRAP;
    endcase

    // wait counter restarts whenever a new state (FETCH or MEM) is entered
    if (state_d != state_q) cnt_d = '0;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench: instruction streams are expanded into
// per-cycle expected outputs from the sequencing rules and compared live.
module tb_multicycle_control;

  localparam int unsigned TO = 16;
  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4;
  localparam logic [6:0] OPC  [5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
  localparam logic [1:0] AOP  [5] = '{2'b00, 2'b10, 2'b01, 2'b01, 2'b11};
  localparam bit         ASRC [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam int PH_IDLE = 0, PH_F = 1, PH_D = 2, PH_E = 3, PH_M = 4, PH_W = 5, PH_T = 6;

  typedef struct {
    int         ph;
    logic [6:0] op;
    logic       ir;
    logic       dr;
    logic       z;
    logic [12:0] exp;
  } cyc_t;

  cyc_t q[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = '0;
  logic       zero = 1'b0;
  logic       ir_we, pc_we, pc_sel, alusrc, mw, m2r, rw, trap, cause;
  logic [1:0] aluop;
  logic [12:0] act;
  int checks = 0;
  int errors = 0;

  multicycle_control_if mcif ();

  multicycle_control #(.ALUOP_W(2), .MEM_TIMEOUT(TO), .EN_BRANCH(1'b1)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .Op_i         (op),
    .zero_i       (zero),
    .mem_if       (mcif.master),
    .ir_we_o      (ir_we),
    .pc_we_o      (pc_we),
    .pc_sel_o     (pc_sel),
    .ALUOp_o      (aluop),
    .ALUSrc_o     (alusrc),
    .MemWrite_o   (mw),
    .MemToReg_o   (m2r),
    .RegWrite_o   (rw),
    .trap_o       (trap),
    .trap_cause_o (cause)
  );

  always #5 clk = ~clk;

  assign act = {mcif.imem_req_o, mcif.dmem_req_o, ir_we, pc_we, pc_sel, aluop, alusrc,
                mw, m2r, rw, trap, cause};

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b (ireq dreq irwe pcwe pcsel aop[2] asrc mw m2r rw trap cause)",
               tag, $time, got, exp);
    end
  endtask

  function automatic logic [12:0] ev(bit ireq, bit dreq, bit irwe, bit pcwe, bit pcsel,
                                      logic [1:0] aop, bit asrc, bit mwr, bit mtr, bit rwr,
                                      bit trp, bit cse);
    return {ireq, dreq, irwe, pcwe, pcsel, aop, asrc, mwr, mtr, rwr, trp, cse};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  function automatic bit is_legal(logic [6:0] o);
    for (int i = 0; i < 5; i++) if (o == OPC[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic string ph_name(int ph);
    case (ph)
      PH_IDLE: return "idle_after_reset";
      PH_F:    return "fetch";
      PH_D:    return "decode";
      PH_E:    return "exec";
      PH_M:    return "mem";
      PH_W:    return "writeback";
      default: return "trap";
    endcase
  endfunction

  // Mostly short waits, sometimes long, occasionally exactly the limit
  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 7) return int'($urandom_range(0, 2));
    if (r < 9) return int'($urandom_range(3, 15));
    return int'(TO);
  endfunction

  task automatic push(int ph, logic [6:0] o, logic ir, logic dr, logic z, logic [12:0] e);
    cyc_t c;
    c.ph = ph; c.op = o; c.ir = ir; c.dr = dr; c.z = z; c.exp = e;
    q.push_back(c);
  endtask

  task automatic add_fetch(int w);
    for (int i = 0; i < w; i++) push(PH_F, rop(), 1'b0, rb(), rb(), ev(1,0,0,0,0,2'b00,0,0,0,0,0,0));
    push(PH_F, rop(), 1'b1, rb(), rb(), ev(1,0,1,1,0,2'b00,0,0,0,0,0,0));
  endtask

  task automatic add_trap(bit cse);
    for (int i = 0; i < 4; i++) push(PH_T, rop(), rb(), rb(), rb(), ev(0,0,0,0,0,2'b00,0,0,0,0,1,cse));
  endtask

  // mem_mode: 0 completes, 1 never gets dmem ready, 2 stops mid-wait
  task automatic add_instr(int k, int fw, int mw_n, bit z, int mem_mode);
    logic [1:0] a;
    bit s;
    int nw;
    a = AOP[k];
    s = ASRC[k];
    add_fetch(fw);
    push(PH_D, OPC[k], rb(), rb(), rb(), '0);
    if (k == K_BR) begin
      push(PH_E, rop(), rb(), rb(), z, ev(0,0,0,z,z,a,s,0,0,0,0,0));
      return;
    end
    push(PH_E, rop(), rb(), rb(), rb(), ev(0,0,0,0,0,a,s,0,0,0,0,0));
    if (k == K_LD || k == K_ST) begin
      nw = (mem_mode == 1) ? int'(TO) + 1 : mw_n;
      for (int i = 0; i < nw; i++)
        push(PH_M, rop(), rb(), 1'b0, rb(), ev(0,1,0,0,0,a,s,k == K_ST,0,0,0,0));
      if (mem_mode == 1) begin
        add_trap(1'b1);
        return;
      end
      if (mem_mode == 2) return;
      push(PH_M, rop(), rb(), 1'b1, rb(), ev(0,1,0,0,0,a,s,k == K_ST,0,0,0,0));
      if (k == K_ST) return;
    end
    push(PH_W, rop(), rb(), rb(), rb(), ev(0,0,0,0,0,a,s,0,k == K_LD,1,0,0));
  endtask

  task automatic add_illegal(logic [6:0] o, int fw);
    add_fetch(fw);
    push(PH_D, o, rb(), rb(), rb(), '0);
    add_trap(1'b0);
  endtask

  task automatic run_queue();
    cyc_t c;
    while (q.size() != 0) begin
      c = q.pop_front();
      @(negedge clk);
      op = c.op;
      mcif.imem_ready_i = c.ir;
      mcif.dmem_ready_i = c.dr;
      zero = c.z;
      #1;
      check(ph_name(c.ph), act, c.exp);
    end
  endtask

  // Reset lands asynchronously in the middle of a cycle; release before the next negedge
  task automatic do_reset(input logic [12:0] pre);
    @(negedge clk);
    op = rop();
    mcif.imem_ready_i = 1'b0;
    mcif.dmem_ready_i = 1'b0;
    zero = rb();
    #1;
    check("pre_reset", act, pre);
    #1 rst_n = 1'b0;
    #1 check("reset_async", act, '0);
    @(posedge clk);
    mcif.imem_ready_i = 1'b1;
    mcif.dmem_ready_i = 1'b1;
    @(posedge clk);
    #1 check("reset_hold", act, '0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [12:0] pre;
    logic [6:0]  ill;
    int          n, ending, k;

    mcif.imem_ready_i = 1'b0;
    mcif.dmem_ready_i = 1'b0;
    #1 check("reset_init", act, '0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Directed: all classes, branch both ways, wait boundaries, all-ones opcode
    push(PH_IDLE, rop(), rb(), rb(), rb(), '0);
    add_instr(K_R, 0, 0, 1'b0, 0);
    add_instr(K_LD, 1, 3, 1'b0, 0);
    add_instr(K_BR, 0, 0, 1'b1, 0);
    add_instr(K_BR, 2, 0, 1'b0, 0);
    add_instr(K_ST, 0, 0, 1'b0, 0);
    add_instr(K_I, int'(TO), 0, 1'b0, 0);
    add_instr(K_LD, 0, int'(TO), 1'b0, 0);
    add_instr(K_ST, 0, int'(TO), 1'b0, 0);
    add_illegal(7'h7F, 0);
    run_queue();
    do_reset(ev(0,0,0,0,0,2'b00,0,0,0,0,1,0));

    // Directed: data memory never answers
    push(PH_IDLE, rop(), rb(), rb(), rb(), '0);
    add_instr(K_LD, 0, 0, 1'b0, 1);
    run_queue();
    do_reset(ev(0,0,0,0,0,2'b00,0,0,0,0,1,1));

    // Directed: reset while a load waits in MEM
    push(PH_IDLE, rop(), rb(), rb(), rb(), '0);
    add_instr(K_LD, 0, 3, 1'b0, 2);
    run_queue();
    do_reset(ev(0,1,0,0,0,2'b01,1,0,0,0,0,0));

    for (int seg = 0; seg < 30; seg++) begin
      push(PH_IDLE, rop(), rb(), rb(), rb(), '0);
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++)
        add_instr(int'($urandom_range(0, 4)), rand_wait(), rand_wait(), rb(), 0);
      ending = int'($urandom_range(0, 4));
      case (ending)
        1: begin
          do ill = rop(); while (is_legal(ill));
          add_illegal(ill, rand_wait());
          pre = ev(0,0,0,0,0,2'b00,0,0,0,0,1,0);
        end
        2: begin
          for (int i = 0; i <= int'(TO); i++)
            push(PH_F, rop(), 1'b0, rb(), rb(), ev(1,0,0,0,0,2'b00,0,0,0,0,0,0));
          add_trap(1'b1);
          pre = ev(0,0,0,0,0,2'b00,0,0,0,0,1,1);
        end
        3: begin
          k = ($urandom_range(0, 1) != 0) ? K_LD : K_ST;
          add_instr(k, rand_wait(), 0, 1'b0, 1);
          pre = ev(0,0,0,0,0,2'b00,0,0,0,0,1,1);
        end
        4: begin
          k = ($urandom_range(0, 1) != 0) ? K_LD : K_ST;
          add_instr(k, rand_wait(), int'($urandom_range(0, 5)), 1'b0, 2);
          pre = ev(0,1,0,0,0,2'b01,1,k == K_ST,0,0,0,0);
        end
        default: pre = ev(1,0,0,0,0,2'b00,0,0,0,0,0,0);
      endcase
      run_queue();
      do_reset(pre);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
